gsim_ctrl: RTL and testbench
============================

GSIM_CTRL -- requirements
Module: gsim_ctrl

Interface
REQ-001 The block SHALL have input port clk, 1 bit: clock; all state changes on its rising edge.
REQ-002 The block SHALL have input port reset, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have input port in_en, 1 bit: b-sample strobe; one offset word is present on the external bus per asserted cycle.
REQ-004 The block SHALL have input port max_iter, 5 bits: sweep limit, sampled on the 16th accepted in_en; value 0 SHALL be treated as 1.
REQ-005 The block SHALL have output port b_we, 1 bit: b-memory write enable.
REQ-006 The block SHALL have output port b_addr, 4 bits: b-memory write address.
REQ-007 The block SHALL have output port upd_valid, 1 bit: update request to the shared Gauss-Seidel update unit.
REQ-008 The block SHALL have output port upd_idx, 4 bits: unknown index to update.
REQ-009 The block SHALL have input port upd_ready, 1 bit: update unit accepts the request this cycle.
REQ-010 The block SHALL have input port upd_ack, 1 bit: completion pulse for the single outstanding update.
REQ-011 The block SHALL have input port upd_small, 1 bit: |x_new - x_old| below threshold; qualified by upd_ack.
REQ-012 The block SHALL have output port x_rd_en, 1 bit: answer-memory read enable.
REQ-013 The block SHALL have output port x_rd_addr, 4 bits: answer-memory read address.
REQ-014 The block SHALL have output port out_valid, 1 bit: x word valid on the downstream bus.
REQ-015 The block SHALL have output port busy, 1 bit: high in every state except RECV.
REQ-016 The block SHALL have output port iter_cnt, 5 bits: number of completed sweeps.

Function
REQ-017 The FSM SHALL have states RECV, CALC, WAIT, SEND; reset state SHALL be RECV.
REQ-018 In RECV, b_we SHALL equal in_en (combinational), b_addr SHALL equal the sample counter, and the counter SHALL increment on each in_en.
REQ-019 On the in_en with counter 15, the block SHALL latch max_iter, clear the counter, iter_cnt and the all_small flag (set to 1), and go to CALC next cycle.
REQ-020 in_en outside RECV SHALL be ignored: no b_we, no counter change.
REQ-021 In CALC, upd_valid SHALL be 1 with upd_idx = sweep index; upd_valid and upd_idx SHALL hold stable until upd_ready=1.
REQ-022 On a cycle with upd_valid and upd_ready, the block SHALL go to WAIT; at most one update SHALL be outstanding (Gauss-Seidel ordering).
REQ-023 In WAIT, upd_valid SHALL be 0; on upd_ack, all_small SHALL be ANDed with upd_small.
REQ-024 On upd_ack with index < 15, the block SHALL increment the index and return to CALC.
REQ-025 On upd_ack with index 15, the block SHALL increment iter_cnt (saturating at 31) and clear the index.
REQ-026 On that same index-15 ack, if the updated all_small = 1 or the new iter_cnt = latched limit, the block SHALL go to SEND.
REQ-027 Otherwise, on that same index-15 ack, the block SHALL return to CALC with all_small reset to 1.
REQ-028 upd_ack in RECV, CALC or SEND SHALL be ignored.
REQ-029 In SEND, x_rd_en SHALL be 1 for exactly 16 consecutive cycles with x_rd_addr 0..15.
REQ-030 out_valid SHALL be x_rd_en delayed by one cycle (1-cycle memory read latency).
REQ-031 After the 16th read, the block SHALL return to RECV and be able to accept in_en in the next cycle.
REQ-032 When out_valid for address 15 is high, RECV SHALL already be active.
REQ-033 Minimum CALC-to-SEND latency: 2 cycles per unknown when upd_ready and upd_ack respond immediately.
REQ-034 When not driven, b_addr, upd_idx and x_rd_addr SHALL hold their last values; consumers use only the qualifying enables.

Reset
REQ-035 While reset is asserted, the block SHALL set state to RECV and set all counters, iter_cnt and the latched limit to 0.
REQ-036 While reset is asserted, the block SHALL drive b_we, upd_valid, x_rd_en, out_valid and busy to 0, and all_small to 1.
REQ-037 Reset mid-CALC or mid-WAIT SHALL abandon the outstanding update; a later upd_ack SHALL be ignored.
REQ-038 After reset deassertion, the first in_en SHALL write b_addr 0.

Verification
REQ-039 Test: 16 in_en pulses, max_iter=3, ack 1 cycle after ready, upd_small=0 -> b_addr 0..15, 48 ordered updates, iter_cnt=3, 16 reads, out_valid 16 cycles.
REQ-040 Test: max_iter=10, upd_small=1 on all acks of sweep 2 -> SEND after iter_cnt=2.
REQ-041 Test: upd_ready low 5 cycles on idx 7 -> upd_valid/upd_idx=7 held stable; no second request issued before ack.
REQ-042 Test: max_iter=0 -> exactly one sweep, iter_cnt=1; spurious upd_ack in RECV/SEND and in_en during CALC cause no state change.
REQ-043 Test: reset asserted in WAIT at idx 9 of sweep 2 -> all outputs 0, RECV; next in_en writes b_addr 0.
REQ-044 Test: back-to-back frames with in_en asserted the cycle after the last x_rd_en -> first sample accepted at b_addr 0.

Source files
------------

// File: rtl/gsim_ctrl.sv
// gsim_ctrl: sequencer for a Gauss-Seidel solver. It collects 16 b-samples, runs
// 16-unknown update sweeps until the sweep converges or hits the limit, then streams x out.
//   clk, reset             clock, asynchronous active-high reset
//   in_en, max_iter        b-sample strobe, sweep limit (0 counts as 1) taken with the 16th sample
//   b_we, b_addr           b-memory write port
//   upd_valid/idx/ready    request to the shared update unit
//   upd_ack, upd_small     update completion, convergence flag qualified by upd_ack
//   x_rd_en, x_rd_addr     answer-memory read port
//   out_valid              read data valid, one cycle after x_rd_en
//   busy, iter_cnt         not receiving, completed sweeps
module gsim_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_en,
    input  logic [4:0] max_iter,
    output logic       b_we,
    output logic [3:0] b_addr,
    output logic       upd_valid,
    output logic [3:0] upd_idx,
    input  logic       upd_ready,
    input  logic       upd_ack,
    input  logic       upd_small,
    output logic       x_rd_en,
    output logic [3:0] x_rd_addr,
    output logic       out_valid,
    output logic       busy,
    output logic [4:0] iter_cnt
);
    typedef enum logic [1:0] {RECV, CALC, WAIT, SEND} state_t;
    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_idx;
    logic [3:0] r_rd;
    logic [4:0] r_limit;
    logic [4:0] r_iter;
    logic       r_all_small;
    logic       r_upd_valid;
    logic       r_rd_en;
    logic       r_out_valid;
    logic       r_busy;
    logic       w_small;
    logic [4:0] w_iter_next;
    assign w_small     = r_all_small & upd_small;
    assign w_iter_next = (r_iter == 5'd31) ? r_iter : r_iter + 5'd1;
    // The 4-bit sample, index and read counters wrap to 0 on their last step,
    // so no explicit clears are needed when a phase ends.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= RECV;
            r_cnt       <= 4'd0;
            r_idx       <= 4'd0;
            r_rd        <= 4'd0;
            r_limit     <= 5'd0;
            r_iter      <= 5'd0;
            r_all_small <= 1'b1;
            r_upd_valid <= 1'b0;
            r_rd_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_out_valid <= r_rd_en;
            case (r_state)
                RECV: if (in_en) begin
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        r_limit     <= (max_iter == 5'd0) ? 5'd1 : max_iter;
                        r_iter      <= 5'd0;
                        r_all_small <= 1'b1;
                        r_state     <= CALC;
                        r_upd_valid <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                CALC: if (upd_ready) begin
                    r_state     <= WAIT;
                    r_upd_valid <= 1'b0;
                end
                WAIT: if (upd_ack) begin
                    r_idx <= r_idx + 4'd1;
                    if (r_idx != 4'd15) begin
                        r_all_small <= w_small;
                        r_state     <= CALC;
                        r_upd_valid <= 1'b1;
                    end else begin
                        r_iter <= w_iter_next;
                        if (w_small || w_iter_next == r_limit) begin
                            r_all_small <= w_small;
                            r_state     <= SEND;
                            r_rd_en     <= 1'b1;
                        end else begin
                            r_all_small <= 1'b1;
                            r_state     <= CALC;
                            r_upd_valid <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    r_rd <= r_rd + 4'd1;
                    if (r_rd == 4'd15) begin
                        r_state <= RECV;
                        r_rd_en <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
            endcase
        end
    end
    assign b_we      = in_en & (r_state == RECV) & ~reset;
    assign b_addr    = r_cnt;
    assign upd_valid = r_upd_valid;
    assign upd_idx   = r_idx;
    assign x_rd_en   = r_rd_en;
    assign x_rd_addr = r_rd;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign iter_cnt  = r_iter;
endmodule

// File: tb/tb_gsim_ctrl.sv
// tb_gsim_ctrl: randomized self-checking bench for gsim_ctrl with an update-unit responder and sweep model
module tb_gsim_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_en;
    logic [4:0] max_iter;
    logic       b_we;
    logic [3:0] b_addr;
    logic       upd_valid;
    logic [3:0] upd_idx;
    logic       upd_ready;
    logic       upd_ack;
    logic       upd_small;
    logic       x_rd_en;
    logic [3:0] x_rd_addr;
    logic       out_valid;
    logic       busy;
    logic [4:0] iter_cnt;
    int errors = 0;
    int checks = 0;
    int got[$];
    bit rand_ready = 0;
    bit rand_small = 0;
    bit noise = 0;
    int small_sweep = 0;
    int stall_idx = -1;
    int stall_left = 0;
    int kill_n = -1;
    bit killed = 0;
    int late_ack = 0;
    gsim_ctrl dut (
        .clk(clk), .reset(reset), .in_en(in_en), .max_iter(max_iter),
        .b_we(b_we), .b_addr(b_addr), .upd_valid(upd_valid), .upd_idx(upd_idx),
        .upd_ready(upd_ready), .upd_ack(upd_ack), .upd_small(upd_small),
        .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr), .out_valid(out_valid),
        .busy(busy), .iter_cnt(iter_cnt)
    );
    always #5 clk = ~clk;
    // Update unit: accepts requests (optionally stalling), acks one cycle after acceptance.
    initial begin : responder
        bit hs_pend;
        bit withheld;
        bit rdy;
        int hs_idx;
        int sweep;
        logic [3:0] w_idx;
        hs_pend = 0;
        withheld = 0;
        hs_idx = 0;
        w_idx = 4'd0;
        upd_ready = 0;
        upd_ack = 0;
        upd_small = 0;
        forever begin
            @(negedge clk);
            upd_ready = 0;
            upd_ack = 0;
            upd_small = 0;
            if (reset) begin
                hs_pend = 0;
                withheld = 0;
                if (late_ack == 1) late_ack = 2;
            end else if (late_ack == 2) begin
                upd_ack = 1;
                upd_small = 1;
                late_ack = 0;
            end else if (hs_pend) begin
                hs_pend = 0;
                checks++;
                if (upd_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL upd_outstanding: upd_valid=%b required 0 while an update is outstanding", upd_valid);
                end
                sweep = got.size() / 16 + 1;
                got.push_back(hs_idx);
                if (kill_n == got.size()) begin
                    killed = 1;
                    late_ack = 1;
                end else begin
                    upd_ack = 1;
                    upd_small = rand_small ? ((sweep == small_sweep) ? 1'b1 : (hs_idx == 0 ? 1'b0 : 1'($urandom_range(0, 1)))) : 1'b0;
                end
            end else if (upd_valid) begin
                if (withheld) begin
                    checks++;
                    if (upd_idx !== w_idx) begin
                        errors++;
                        $display("FAIL upd_hold: upd_idx=%0d required %0d while not ready", upd_idx, w_idx);
                    end
                end
                if (stall_left > 0 && int'(upd_idx) == stall_idx) begin
                    stall_left--;
                    rdy = 0;
                end else rdy = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
                upd_ready = rdy;
                withheld = !rdy;
                w_idx = upd_idx;
                hs_pend = rdy;
                hs_idx = int'(upd_idx);
            end else begin
                if (withheld) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_hold: upd_valid=0 required 1 while not ready (idx %0d)", w_idx);
                    withheld = 0;
                end
                if (noise && (!busy || x_rd_en)) begin
                    upd_ack = 1'($urandom_range(0, 1));
                    upd_small = 1;
                end
            end
        end
    end
    // Sweeps run before SEND: stop on the all-small sweep or when the saturating count reaches the limit.
    function automatic int exp_sweeps(int mi, int ssw);
        int lim = (mi == 0) ? 1 : mi;
        for (int s = 1; s <= 64; s++) if (s == ssw || ((s > 31) ? 31 : s) == lim) return s;
        return 64;
    endfunction
    task automatic send_samples(input int mi, input int n, input bit now);
        for (int k = 0; k < n; k++) begin
            if (!(now && k == 0)) @(negedge clk);
            in_en = 1;
            max_iter = (k == 15) ? 5'(mi) : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (b_we !== 1'b1 || b_addr !== 4'(k) || busy !== 1'b0) begin
                errors++;
                $display("FAIL b_write: b_we=%b b_addr=%0d busy=%b required 1/%0d/0", b_we, b_addr, busy, k);
            end
            if (k < 15) repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_en = 0;
            end
        end
        @(negedge clk);
        in_en = 0;
        #1;
        if (n == 16) begin
            checks++;
            if (busy !== 1'b1 || upd_valid !== 1'b1 || upd_idx !== 4'd0) begin
                errors++;
                $display("FAIL enter_calc: busy=%b upd_valid=%b upd_idx=%0d required 1/1/0", busy, upd_valid, upd_idx);
            end
        end
    endtask
    task automatic wait_send(input int es, input bit noise_on);
        int rd_exp = 0;
        int ov = 0;
        bit prev_rd = 0;
        bit done = 0;
        bit ok;
        for (int c = 0; c < 8000 && !done; c++) begin
            @(negedge clk);
            in_en = (noise_on && busy) ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            if (in_en) begin
                checks++;
                if (b_we !== 1'b0) begin
                    errors++;
                    $display("FAIL ignore_in_en: b_we=%b required 0 while busy", b_we);
                end
            end
            if (rd_exp > 0 && rd_exp < 16) begin
                checks++;
                if (x_rd_en !== 1'b1) begin
                    errors++;
                    $display("FAIL rd_burst: x_rd_en=%b required 1 at read %0d", x_rd_en, rd_exp);
                end
            end
            if (x_rd_en) begin
                if (rd_exp == 0) begin
                    checks++;
                    if (iter_cnt !== 5'(es)) begin
                        errors++;
                        $display("FAIL iter_cnt: got %0d required %0d", iter_cnt, es);
                    end
                    ok = (got.size() == 16 * es);
                    foreach (got[i]) if (got[i] != i % 16) ok = 0;
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL upd_order: %0d ordered updates observed, required %0d in 0..15 order", got.size(), 16 * es);
                    end
                end
                checks++;
                if (x_rd_addr !== 4'(rd_exp)) begin
                    errors++;
                    $display("FAIL rd_addr: got %0d required %0d", x_rd_addr, rd_exp);
                end
                rd_exp++;
            end
            checks++;
            if (out_valid !== prev_rd) begin
                errors++;
                $display("FAIL out_valid: got %b required %b", out_valid, prev_rd);
            end
            if (out_valid) ov++;
            if (ov == 16) begin
                checks++;
                if (busy !== 1'b0 || x_rd_en !== 1'b0) begin
                    errors++;
                    $display("FAIL send_done: busy=%b x_rd_en=%b required 0/0 at last out_valid", busy, x_rd_en);
                end
                done = 1;
            end
            prev_rd = x_rd_en;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d of 16 out_valid cycles seen", ov);
        end
    endtask
    task automatic run_frame(input int mi, input int ssw, input bit nz, input bit now);
        got.delete();
        small_sweep = ssw;
        noise = nz;
        send_samples(mi, 16, now);
        wait_send(exp_sweeps(mi, rand_small ? ssw : 0), nz);
        noise = 0;
    endtask
    task automatic check_idle(input string name);
        #1;
        checks++;
        if (b_we !== 1'b0 || upd_valid !== 1'b0 || x_rd_en !== 1'b0 || out_valid !== 1'b0 ||
            busy !== 1'b0 || iter_cnt !== 5'd0 || b_addr !== 4'd0) begin
            errors++;
            $display("FAIL %s: b_we=%b upd_valid=%b x_rd_en=%b out_valid=%b busy=%b iter_cnt=%0d b_addr=%0d required all 0",
                     name, b_we, upd_valid, x_rd_en, out_valid, busy, iter_cnt, b_addr);
        end
    endtask
    task automatic test_reset;
        reset = 1;
        in_en = 1;
        repeat (2) @(negedge clk);
        check_idle("reset_state");
        @(negedge clk);
        reset = 0;
        in_en = 0;
    endtask
    task automatic test_basic;
        rand_ready = 0;
        rand_small = 0;
        run_frame(3, 0, 0, 0);
    endtask
    task automatic test_converge;
        rand_ready = 1;
        rand_small = 1;
        run_frame(10, 2, 0, 0);
    endtask
    task automatic test_stall;
        rand_ready = 0;
        rand_small = 0;
        stall_idx = 7;
        stall_left = 5;
        run_frame(1, 0, 0, 0);
        checks++;
        if (stall_left !== 0) begin
            errors++;
            $display("FAIL stall: %0d stall cycles unused, required 0", stall_left);
        end
        stall_idx = -1;
    endtask
    task automatic test_zero_limit;
        rand_ready = 1;
        rand_small = 1;
        run_frame(0, 0, 1, 0);
    endtask
    task automatic test_reset_in_wait;
        rand_ready = 1;
        rand_small = 0;
        got.delete();
        kill_n = 26;
        send_samples(10, 16, 0);
        for (int c = 0; c < 3000 && !killed; c++) @(negedge clk);
        checks++;
        if (!killed) begin
            errors++;
            $display("FAIL reach_wait: %0d updates seen, required 26", got.size());
        end
        reset = 1;
        in_en = 1;
        check_idle("reset_in_wait");
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        in_en = 0;
        kill_n = -1;
        killed = 0;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || upd_valid !== 1'b0 || late_ack != 0) begin
            errors++;
            $display("FAIL late_ack: busy=%b upd_valid=%b required 0/0 after stale ack", busy, upd_valid);
        end
        run_frame(2, 0, 0, 0);
    endtask
    task automatic test_back_to_back;
        rand_ready = 0;
        rand_small = 0;
        run_frame(1, 0, 0, 0);
        run_frame(2, 0, 0, 1);
    endtask
    task automatic test_random;
        rand_ready = 1;
        rand_small = 1;
        for (int i = 0; i < 4; i++)
            run_frame($urandom_range(0, 31), $urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask
    initial begin
        reset = 1;
        in_en = 0;
        max_iter = 5'd0;
        test_reset;
        test_basic;
        test_converge;
        test_stall;
        test_zero_limit;
        test_reset_in_wait;
        test_back_to_back;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
